mem_port_arbiter: RTL and testbench

Shares the single unified memory port between instruction fetch (IF) and the data-memory stage (MEM), where the MEM stage is driven by the decoder's memRead/memWrite signals. It grants one requester at a time and sequences a variable-latency memory transaction. It returns read data or a done pulse to the winner, and produces per-requester stall signals that freeze the pipeline while an access is outstanding. It sits between the fetch/MEM stages and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/arb_starve_cnt.sv | 28 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned AddrWDef = 16;
  localparam int unsigned DataWDef = 16;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } arb_state_t;

  typedef enum logic {
    OwnIf,
    OwnDm
  } arb_owner_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants made while fetch was waiting; hit forces a fetch grant.
module arb_starve_cnt #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] cnt_q;

  assign hit = (cnt_q == CntW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !hit) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and data stages (data first).
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = AddrWDef,
  parameter int unsigned DATA_W     = DataWDef,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t        state_q;
  arb_owner_t        owner_q;
  logic              kill_pend_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;
  logic              if_done_q, dm_done_q;
  logic              force_if, grant_if, kill_now;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic starve_hit, starve_inc, starve_clr;

  assign starve_inc = (state_q == StIdle) && dm_req && !grant_if && if_req;
  assign starve_clr = (state_q == StIdle) && grant_if;
  assign force_if   = starve_hit && if_req;

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (starve_inc),
    .clr  (starve_clr),
    .hit  (starve_hit)
  );
`else
  logic unused_starve;
  assign unused_starve = ^STARVE_MAX;
  assign force_if      = 1'b0;
`endif

  assign grant_if = if_req && (!dm_req || force_if);
  assign kill_now = (owner_q == OwnIf) && if_kill;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  // A kill landing in the done cycle still swallows the completion.
  assign if_done   = if_done_q && !if_kill;
  assign dm_done   = dm_done_q;
  assign if_stall  = if_req && !if_done;
  assign dm_stall  = dm_req && !dm_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      kill_pend_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_req || dm_req) begin
            state_q   <= StBusy;
            mem_req_q <= 1'b1;
            if (grant_if) begin
              owner_q     <= OwnIf;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
            end else begin
              owner_q     <= OwnDm;
              mem_we_q    <= dm_we;
              mem_addr_q  <= dm_addr;
              mem_wdata_q <= dm_wdata;
            end
          end
        end
        StBusy: begin
          if (kill_now) kill_pend_q <= 1'b1;
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= StDone;
            if (owner_q == OwnDm) begin
              dm_done_q <= 1'b1;
              if (!mem_we_q) dm_rdata_q <= mem_rdata;
            end else if (!kill_pend_q && !kill_now) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end
        end
        StDone: begin
          kill_pend_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: memory model checks port fields, monitor checks done pulses.
module tb_mem_port_arbiter;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int unsigned lat;
  } mem_exp_t;

  typedef struct {
    bit          is_if;
    logic [15:0] rdata;
  } done_exp_t;

  logic        clk, rst_n;
  logic        if_req, if_kill, if_done, if_stall;
  logic [15:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done, dm_stall;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  mem_exp_t  mem_q[$];
  done_exp_t done_q[$];
  int        n_checks, n_fail;

  mem_port_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .STARVE_MAX(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_kill  (if_kill),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .if_stall (if_stall),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_done  (dm_done),
    .dm_stall (dm_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_mem(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                          input logic [15:0] rdata, input int unsigned lat);
    mem_exp_t e;
    e.addr = addr; e.we = we; e.wdata = wdata; e.rdata = rdata; e.lat = lat;
    mem_q.push_back(e);
  endtask

  task automatic push_done(input bit is_if, input logic [15:0] rdata);
    done_exp_t d;
    d.is_if = is_if; d.rdata = rdata;
    done_q.push_back(d);
  endtask

  // Returns cycles from request cycle (0) to the done cycle; optionally checks requester stall.
  task automatic wait_done(input bit want_if, input bit chk_stall, output int lat);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      got = want_if ? if_done : dm_done;
      if (chk_stall) check(want_if ? "if_stall" : "dm_stall", want_if ? if_stall : dm_stall, !got);
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done pulse, expected one within 60 cycles");
    end
    lat = n - 1;
  endtask

  // Memory model: acks the head expectation after its latency and checks the presented fields.
  initial begin
    mem_exp_t    e;
    int unsigned wcnt;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wcnt      = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (rst_n && mem_req && mem_q.size() > 0) begin
        if (wcnt >= mem_q[0].lat) begin
          e = mem_q.pop_front();
          check("mem_addr", mem_addr, e.addr);
          check("mem_we", mem_we, e.we);
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
          mem_ack   = 1'b1;
          mem_rdata = e.rdata;
          wcnt      = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Done monitor.
  initial begin
    done_exp_t d;
    forever begin
      @(negedge clk);
      if (rst_n && (if_done || dm_done)) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got if_done=%0b dm_done=%0b, expected none", if_done,
                   dm_done);
        end else begin
          d = done_q.pop_front();
          check("done_owner_is_if", if_done, d.is_if);
          check("done_owner_is_dm", dm_done, !d.is_if);
          if (d.is_if) check("if_rdata", if_rdata, d.rdata);
          else         check("dm_rdata", dm_rdata, d.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_if_done"}, if_done, 0);
    check({tag, "_dm_done"}, dm_done, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_dm_rdata"}, dm_rdata, 0);
  endtask

  initial begin
    int lat;
    int dm_seen, dm_before_if, n_dm, guard;
    bit fetch_done;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if_req = 0; if_addr = 0; if_kill = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    #1;
    check_all_zero("reset");
    check("reset_if_stall", if_stall, 0);
    check("reset_dm_stall", dm_stall, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Fetch only, ack 3 cycles after mem_req.
    push_mem(16'h0010, 1'b0, 16'h0000, 16'hBEEF, 3);
    push_done(1'b1, 16'hBEEF);
    if_addr = 16'h0010;
    if_req  = 1'b1;
    wait_done(1'b1, 1'b1, lat);
    if_req = 1'b0;
    check("fetch_latency", lat, 5);
    tick();

    // Data read.
    push_mem(16'h0040, 1'b0, 16'h0000, 16'hCAFE, 2);
    push_done(1'b0, 16'hCAFE);
    dm_addr = 16'h0040;
    dm_we   = 1'b0;
    dm_req  = 1'b1;
    wait_done(1'b0, 1'b1, lat);
    dm_req = 1'b0;
    check("dm_read_latency", lat, 4);
    tick();

    // Collision: data write wins, fetch follows; write leaves dm_rdata unchanged.
    push_mem(16'h0020, 1'b1, 16'h1234, 16'hDEAD, 1);
    push_mem(16'h0030, 1'b0, 16'h0000, 16'h5A5A, 0);
    push_done(1'b0, 16'hCAFE);
    push_done(1'b1, 16'h5A5A);
    dm_addr  = 16'h0020;
    dm_wdata = 16'h1234;
    dm_we    = 1'b1;
    dm_req   = 1'b1;
    if_addr  = 16'h0030;
    if_req   = 1'b1;
    wait_done(1'b0, 1'b1, lat);
    check("coll_dm_latency", lat, 3);
    check("coll_if_stall_loser", if_stall, 1);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    wait_done(1'b1, 1'b1, lat);
    if_req = 1'b0;
    check("coll_if_after_dm", lat, 2);
    tick();

    // Kill during fetch BUSY: ack consumed, no done, if_rdata kept.
    push_mem(16'h0050, 1'b0, 16'h0000, 16'h1111, 3);
    if_addr = 16'h0050;
    if_req  = 1'b1;
    tick();
    tick();
    check("kill_mem_req_busy", mem_req, 1);
    if_kill = 1'b1;
    if_req  = 1'b0;
    tick();
    if_kill = 1'b0;
    repeat (6) tick();
    check("kill_if_rdata_kept", if_rdata, 16'h5A5A);
    check("kill_ack_consumed", mem_q.size(), 0);
    check("kill_mem_req_low", mem_req, 0);

    // Next fetch after a kill proceeds normally.
    push_mem(16'h0060, 1'b0, 16'h0000, 16'h2222, 1);
    push_done(1'b1, 16'h2222);
    if_addr = 16'h0060;
    if_req  = 1'b1;
    wait_done(1'b1, 1'b1, lat);
    if_req = 1'b0;
    check("post_kill_latency", lat, 3);
    tick();

    // Zero-latency ack.
    push_mem(16'h00B0, 1'b0, 16'h0000, 16'h4444, 0);
    push_done(1'b1, 16'h4444);
    if_addr = 16'h00B0;
    if_req  = 1'b1;
    wait_done(1'b1, 1'b1, lat);
    if_req = 1'b0;
    check("zero_lat_latency", lat, 2);
    tick();

    // Reset while mem_req is high.
    if_addr = 16'h0090;
    if_req  = 1'b1;
    tick();
    tick();
    check("rst_pre_mem_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    if_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    push_mem(16'h00A0, 1'b0, 16'h0000, 16'h3333, 1);
    push_done(1'b1, 16'h3333);
    if_addr = 16'h00A0;
    if_req  = 1'b1;
    wait_done(1'b1, 1'b1, lat);
    if_req = 1'b0;
    check("post_rst_latency", lat, 3);
    tick();

    // Data held continuously with fetch pending.
`ifdef MEM_ARB_STARVE_GUARD_EN
    n_dm = 3;
`else
    n_dm = 5;
`endif
    for (int i = 0; i < n_dm; i++) begin
      push_mem(16'h0070, 1'b0, 16'h0000, 16'h7001 + 16'(i), 0);
      push_done(1'b0, 16'h7001 + 16'(i));
    end
    push_mem(16'h0080, 1'b0, 16'h0000, 16'h8000, 0);
    push_done(1'b1, 16'h8000);
    dm_addr = 16'h0070;
    dm_we   = 1'b0;
    dm_req  = 1'b1;
    if_addr = 16'h0080;
    if_req  = 1'b1;
    dm_seen      = 0;
    dm_before_if = -1;
    fetch_done   = 1'b0;
    guard        = 0;
    while (!fetch_done && guard < 200) begin
      @(negedge clk);
      guard++;
      if (dm_done) begin
        dm_seen++;
`ifndef MEM_ARB_STARVE_GUARD_EN
        if (dm_seen == n_dm) dm_req = 1'b0;
`endif
      end
      if (if_done) begin
        dm_before_if = dm_seen;
        fetch_done   = 1'b1;
        if_req       = 1'b0;
        dm_req       = 1'b0;
      end
    end
    check("starve_dm_before_if", dm_before_if, n_dm);
    repeat (4) tick();

    check("mem_queue_empty", mem_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
